// File: rtl/tdi_pkg.sv
// ============================================================================
// Module   : tdi_pkg
// Purpose  : Shared TDI opcodes, expected responses, state encoding, helpers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tdi_pkg;

   localparam int unsigned c_div_w  = 8;
   localparam int unsigned c_bits_w = 6;

   localparam logic [7:0] c_op_ping  = 8'hA1;
   localparam logic [7:0] c_op_a2    = 8'hA2;
   localparam logic [7:0] c_op_halt  = 8'hA4;
   localparam logic [7:0] c_op_a5    = 8'hA5;
   localparam logic [7:0] c_op_a6    = 8'hA6;
   localparam logic [7:0] c_op_read  = 8'hA8;
   localparam logic [7:0] c_op_write = 8'hA9;

   localparam logic [7:0] c_rsp_ping = 8'h81;
   localparam logic [7:0] c_rsp_ack  = 8'h01;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_OP    = 3'd1,
      S_ADDR  = 3'd2,
      S_WDATA = 3'd3,
      S_RESP  = 3'd4,
      S_DONE  = 3'd5
   } tdi_state_e;

   function automatic logic is_addr_op(input logic [7:0] op);
      return (op == c_op_read) || (op == c_op_write);
   endfunction

   // Opcodes whose response follows the opcode byte directly
   function automatic logic is_direct_rsp_op(input logic [7:0] op);
      return (op == c_op_ping) || (op == c_op_a2) || (op == c_op_halt) ||
             (op == c_op_a5)   || (op == c_op_a6);
   endfunction

   function automatic logic [c_bits_w-1:0] resp_bits(input logic [7:0] op);
      case (op)
         c_op_a2:   return 6'd16;
         c_op_read: return 6'd32;
         default:   return 6'd8;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/tdi_sck_gen.sv
// ============================================================================
// Module   : tdi_sck_gen
// Purpose  : SCK half-period divider with one-cycle rise/fall/sample strobes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tdi_sck_gen
   import tdi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
)
(
   input  logic HCLK,
   input  logic HRESETn,
   input  logic i_run,
   output logic o_sck,
   output logic o_rise,
   output logic o_fall,
   output logic o_sample
);

   localparam logic [c_div_w-1:0] c_half_last = c_div_w'(CLK_DIV - 1);

   logic [c_div_w-1:0] r_cnt;
   logic               r_sck;
   logic               w_half_end;

   assign w_half_end = i_run && (r_cnt == c_half_last);

   // Parked high with a cleared divider whenever no transfer is running
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_cnt <= '0;
         r_sck <= 1'b1;
      end else if (!i_run) begin
         r_cnt <= '0;
         r_sck <= 1'b1;
      end else if (w_half_end) begin
         r_cnt <= '0;
         r_sck <= ~r_sck;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_sck    = r_sck;
   assign o_fall   = w_half_end &  r_sck;
   assign o_rise   = w_half_end & ~r_sck;
   assign o_sample = w_half_end & ~r_sck;

endmodule

`default_nettype wire

// File: rtl/tdi_host.sv
// ============================================================================
// Module   : tdi_host
// Purpose  : TDI serial host: opcode/address/data shift-out, response shift-in.
//            Optional response check enabled by macro TDI_HOST_RSP_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tdi_host
   import tdi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
)
(
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_op,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic        busy,
   output logic        SCK,
   output logic        SDI,
   input  logic        SDO,
   input  logic        SDOE
);

   tdi_state_e          r_state;
   tdi_state_e          w_state_nxt;
   logic [7:0]          r_op;
   logic [31:0]         r_addr;
   logic [31:0]         r_wdata;
   logic [31:0]         r_tx;
   logic [31:0]         r_rx;
   logic [31:0]         w_rx_nxt;
   logic [31:0]         r_rsp_data;
   logic                r_rsp_valid;
   logic [c_bits_w-1:0] r_bit_cnt;
   logic [c_bits_w-1:0] w_phase_bits;
   logic                w_run;
   logic                w_sck;
   logic                w_rise;
   logic                w_fall;
   logic                w_sample;
   logic                w_phase_end;
   logic                w_accept;
   logic                w_done_entry;

   assign w_run = (r_state == S_OP) || (r_state == S_ADDR) ||
                  (r_state == S_WDATA) || (r_state == S_RESP);

   tdi_sck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sck_gen (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .i_run    (w_run),
      .o_sck    (w_sck),
      .o_rise   (w_rise),
      .o_fall   (w_fall),
      .o_sample (w_sample)
   );

   always_comb begin
      w_phase_bits = 6'd8;
      case (r_state)
         S_ADDR, S_WDATA: w_phase_bits = 6'd32;
         S_RESP:          w_phase_bits = resp_bits(r_op);
         default:         w_phase_bits = 6'd8;
      endcase
   end

   // A bit ends on the rise that starts the next one
   assign w_phase_end  = w_rise && (r_bit_cnt == w_phase_bits - 1'b1);
   assign w_accept     = (r_state == S_IDLE) && cmd_valid;
   assign w_done_entry = (r_state != S_DONE) && (w_state_nxt == S_DONE);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (cmd_valid) w_state_nxt = S_OP;
         S_OP:    if (w_phase_end) begin
                     if (is_addr_op(r_op))            w_state_nxt = S_ADDR;
                     else if (is_direct_rsp_op(r_op)) w_state_nxt = S_RESP;
                     else                             w_state_nxt = S_DONE;
                  end
         S_ADDR:  if (w_phase_end)
                     w_state_nxt = (r_op == c_op_write) ? S_WDATA : S_RESP;
         S_WDATA: if (w_phase_end) w_state_nxt = S_DONE;
         S_RESP:  if (w_phase_end) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_rx_nxt = r_rx;
      w_rx_nxt[r_bit_cnt[4:0]] = SDO;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_op        <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_tx        <= '0;
         r_rx        <= '0;
         r_bit_cnt   <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         if (w_accept) begin
            r_op      <= cmd_op;
            r_addr    <= cmd_addr;
            r_wdata   <= cmd_wdata;
            r_tx      <= {24'h0, cmd_op};
            r_rx      <= '0;
            r_bit_cnt <= '0;
         end else if (w_rise) begin
            if (w_phase_end) begin
               r_bit_cnt <= '0;
               case (w_state_nxt)
                  S_ADDR:  r_tx <= r_addr;
                  S_WDATA: r_tx <= r_wdata;
                  default: r_tx <= '0;
               endcase
            end else begin
               r_bit_cnt <= r_bit_cnt + 1'b1;
               r_tx      <= r_tx >> 1;
            end
         end
         if (w_sample && (r_state == S_RESP)) r_rx <= w_rx_nxt;
         if (w_done_entry) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= (r_state == S_RESP) ? w_rx_nxt : 32'h0;
         end
      end
   end

`ifdef TDI_HOST_RSP_CHECK_EN
   logic r_rsp_err;
   logic w_rsp_bad;

   always_comb begin
      w_rsp_bad = 1'b0;
      case (r_op)
         c_op_ping:                   w_rsp_bad = (w_rx_nxt[7:0] != c_rsp_ping);
         c_op_halt, c_op_a5, c_op_a6: w_rsp_bad = (w_rx_nxt[7:0] != c_rsp_ack);
         default:                     w_rsp_bad = 1'b0;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)         r_rsp_err <= 1'b0;
      else if (w_done_entry) r_rsp_err <= (r_state == S_RESP) && w_rsp_bad;
   end

   assign rsp_err = r_rsp_err;
`else
   assign rsp_err = 1'b0;
`endif

   assign cmd_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign SCK       = w_sck;
   assign SDI       = r_tx[0];

`ifndef SYNTHESIS
   // Target must not drive SDO while the opcode is still being shifted out
   a_sdoe_quiet: assert property (@(posedge HCLK) disable iff (!HRESETn)
      (r_state == S_OP) |-> !SDOE);
   a_fall_high: assert property (@(posedge HCLK) disable iff (!HRESETn)
      w_fall |-> w_sck);
`endif

endmodule

`default_nettype wire

// File: tb/tb_tdi_host.sv
// ============================================================================
// Module   : tb_tdi_host
// Purpose  : Self-checking bench for tdi_host with a serial target model.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tdi_host;

   localparam int CLK_DIV = 4;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [7:0]  cmd_op = '0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        busy;
   logic        SCK;
   logic        SDI;
   logic        SDO = 1'b0;
   logic        SDOE = 1'b0;

   tdi_host #(.CLK_DIV(CLK_DIV)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .SCK       (SCK),
      .SDI       (SDI),
      .SDO       (SDO),
      .SDOE      (SDOE)
   );

   always #5 HCLK = ~HCLK;

   int cyc = 0;
   always @(posedge HCLK) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- target model ----------------
   logic [7:0]  ping_resp = 8'h81;
   logic [7:0]  halt_resp = 8'h01;
   logic [7:0]  t_op = '0;
   logic [31:0] t_addr = '0;
   logic [31:0] t_wdata = '0;
   logic        sck_q = 1'b1;
   logic        busy_q = 1'b0;
   int          k = 0;
   int          sdoe_cyc = 0;

   function automatic int rsp_start(input logic [7:0] op);
      case (op)
         8'hA1, 8'hA2, 8'hA4, 8'hA5, 8'hA6: return 8;
         8'hA8:                             return 40;
         default:                           return 0;
      endcase
   endfunction

   function automatic int rsp_len(input logic [7:0] op);
      case (op)
         8'hA1, 8'hA4, 8'hA5, 8'hA6: return 8;
         8'hA2:                      return 16;
         8'hA8:                      return 32;
         default:                    return 0;
      endcase
   endfunction

   function automatic logic [31:0] rsp_val(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [7:0] ping, input logic [7:0] halt);
      case (op)
         8'hA1:        return {24'h0, ping};
         8'hA2:        return 32'h0000_C3A5;
         8'hA4:        return {24'h0, halt};
         8'hA5, 8'hA6: return 32'h0000_0001;
         8'hA8:        return (addr == 32'h2000_0010) ? 32'hDEAD_BEEF : ~addr;
         default:      return 32'h0;
      endcase
   endfunction

   int          w_st;
   int          w_len;
   logic [31:0] w_rv;
   assign w_st  = rsp_start(t_op);
   assign w_len = rsp_len(t_op);
   assign w_rv  = rsp_val(t_op, t_addr, ping_resp, halt_resp);

   // Target samples SDI mid-bit (SCK fall) and presents SDO for the host's end-of-low sample
   always @(negedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         k      <= 0;
         SDOE   <= 1'b0;
         SDO    <= 1'b0;
         sck_q  <= 1'b1;
         busy_q <= 1'b0;
      end else begin
         sck_q  <= SCK;
         busy_q <= busy;
         if (busy && !busy_q) begin
            k        <= 0;
            SDOE     <= 1'b0;
            SDO      <= 1'b0;
            sdoe_cyc <= 0;
         end else begin
            if (SDOE) sdoe_cyc <= sdoe_cyc + 1;
            if (sck_q && !SCK) begin
               if (k < 8)       t_op[k]         <= SDI;
               else if (k < 40) t_addr[k-8]     <= SDI;
               else if (k < 72) t_wdata[k-40]   <= SDI;
               if (k >= w_st && k < w_st + w_len) begin
                  SDOE <= 1'b1;
                  SDO  <= w_rv[k - w_st];
               end else begin
                  SDOE <= 1'b0;
                  SDO  <= 1'b0;
               end
               k <= k + 1;
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [31:0] data;
      logic        err;
      int          acc;
      int          bits;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   function automatic int total_bits(input logic [7:0] op);
      case (op)
         8'hA1, 8'hA4, 8'hA5, 8'hA6: return 16;
         8'hA2:                      return 24;
         8'hA8, 8'hA9:               return 72;
         default:                    return 8;
      endcase
   endfunction

   function automatic logic exp_err(input logic [7:0] op, input logic [31:0] data);
`ifdef TDI_HOST_RSP_CHECK_EN
      if (op == 8'hA1) return data[7:0] != 8'h81;
      if (op == 8'hA4 || op == 8'hA5 || op == 8'hA6) return data[7:0] != 8'h01;
`endif
      return 1'b0;
   endfunction

   always @(negedge HCLK) begin
      if (HRESETn && rsp_valid) begin
         check_eq("rsp_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check_eq("rsp_data", rsp_data, mon_e.data);
            check_eq("rsp_err", 32'(rsp_err), 32'(mon_e.err));
            check_eq("latency", 32'(cyc - mon_e.acc), 32'(2 * CLK_DIV * mon_e.bits + 1));
            check_eq("done_sck", 32'(SCK), 32'd1);
            check_eq("done_ready", 32'(cmd_ready), 32'd0);
         end
      end
   end

   // Called at a negedge; returns one negedge after the accept edge
   task automatic send(input logic [7:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_data);
      exp_t e;
      int   n;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 3000) begin
         @(negedge HCLK);
         n++;
      end
      if (!cmd_ready) begin
         check_eq("accept", 32'(cmd_ready), 32'd1);
      end else begin
         e.data = exp_data;
         e.err  = exp_err(op, exp_data);
         e.acc  = cyc;
         e.bits = total_bits(op);
         sb.push_back(e);
      end
      @(negedge HCLK);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 3000) begin
         @(negedge HCLK);
         n++;
      end
      if (sb.size() != 0) begin
         check_eq(tag, 32'(sb.size()), 32'd0);
         sb.delete();
      end
      @(negedge HCLK);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      repeat (3) @(negedge HCLK);
      check_eq("rst_sck", 32'(SCK), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);
      HRESETn = 1'b1;
      @(negedge HCLK);
      check_eq("rst_sdi", 32'(SDI), 32'd0);
      check_eq("rst_ready", 32'(cmd_ready), 32'd1);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_rsp_data", rsp_data, 32'd0);
      check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);

      // PING
      send(8'hA1, 32'h0, 32'h0, 32'h81);
      wait_drain("ping_drain");

      // READ
      send(8'hA8, 32'h2000_0010, 32'h0, 32'hDEAD_BEEF);
      wait_drain("read_drain");
      check_eq("read_sdi_op", 32'(t_op), 32'hA8);
      check_eq("read_sdi_addr", t_addr, 32'h2000_0010);

      // WRITE
      send(8'hA9, 32'h4000_0000, 32'h1234_5678, 32'h0);
      wait_drain("write_drain");
      check_eq("write_op", 32'(t_op), 32'hA9);
      check_eq("write_addr", t_addr, 32'h4000_0000);
      check_eq("write_data", t_wdata, 32'h1234_5678);
      check_eq("write_no_sdoe", 32'(sdoe_cyc), 32'd0);

      // 16-bit response followed back-to-back by a 0xA5
      send(8'hA2, 32'h0, 32'h0, 32'h0000_C3A5);
      send(8'hA5, 32'h0, 32'h0, 32'h1);
      wait_drain("b2b_drain");

      // HALT with a broken target answer
      halt_resp = 8'h00;
      send(8'hA4, 32'h0, 32'h0, 32'h0);
      wait_drain("halt_drain");
      halt_resp = 8'h01;

      // Unknown opcode
      send(8'h55, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
      wait_drain("unk_drain");

      // Commands while busy are ignored; rsp_data holds
      send(8'hA6, 32'h0, 32'h0, 32'h1);
      for (int i = 0; i < 20; i++) begin
         cmd_valid = 1'b1;
         cmd_op    = 8'hA9;
         if (i % 5 == 0) begin
            check_eq("busy_ready", 32'(cmd_ready), 32'd0);
            check_eq("busy_hold", rsp_data, 32'h0);
         end
         @(negedge HCLK);
      end
      cmd_valid = 1'b0;
      wait_drain("busy_drain");

      // Abort during ADDR bit 17
      send(8'hA8, 32'h2000_0010, 32'h0, 32'hDEAD_BEEF);
      n = 0;
      while (k < 26 && n < 3000) begin
         @(negedge HCLK);
         n++;
      end
      check_eq("abort_reach", 32'(k), 32'd26);
      HRESETn = 1'b0;
      #1;
      check_eq("abort_sck", 32'(SCK), 32'd1);
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      sb.delete();
      @(negedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
      @(negedge HCLK);
      check_eq("abort_ready", 32'(cmd_ready), 32'd1);
      check_eq("abort_rsp_data", rsp_data, 32'd0);

      send(8'hA1, 32'h0, 32'h0, 32'h81);
      wait_drain("ping2_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
